data_mem_responder: RTL

- Memory-side responder for the pipeline's MEM-stage load/store interface.
- Accepts the read/write request held by MEM (enables, ALU-result address, store value).
- Services the request from an internal word array after a configurable number of wait states.
- Returns a one-cycle ready pulse with read data, and drives a combinational stall so the pipeline freezes until the access completes.

---
 rtl/data_mem_responder_pkg.sv | 22 ++
 rtl/mem_word_array.sv | 36 +++
 rtl/data_mem_responder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data memory responder.
//   `WORD_LEN       : data/address width used across the pipeline
//   state_e         : responder FSM encoding (IDLE=0, BUSY=1, DONE=2)
//   DefaultBaseAddr : default byte address of word 0
//   CntWidth        : width of the wait-state counter (WAIT_CYCLES 0..15)

`ifndef WORD_LEN
`define WORD_LEN 32
`endif

package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultBaseAddr = 32'd1024;
  localparam int unsigned CntWidth        = 4;

endpackage

// File: rtl/mem_word_array.sv
// DEPTH x WORD_LEN word storage for the data memory responder.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears every word to 0
//   we    : write enable, writes wdata to word idx at the rising edge
//   idx   : word index for both write and read
//   wdata : write data
//   rdata : asynchronous (combinational) read of word idx

module mem_word_array #(
  parameter int unsigned WORD_LEN = 32,
  parameter int unsigned DEPTH    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WORD_LEN-1:0]      wdata,
  output logic [WORD_LEN-1:0]      rdata
);

  logic [WORD_LEN-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the MEM-stage load/store interface.
// A request is latched in IDLE, held for WAIT_CYCLES wait states in BUSY, performed on the
// last BUSY edge and reported by a one-cycle ready pulse in DONE.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset (clears FSM, outputs and the word array)
//   MEM_R_EN : load request
//   MEM_W_EN : store request (wins when both enables are set)
//   address  : byte address; word index = (address - BASE_ADDR) >> 2
//   dataIn   : store value
//   dataOut  : registered load result, held until the next load completes
//   ready    : registered access-complete pulse
//   stall    : combinational, (MEM_R_EN | MEM_W_EN) & ~ready
//   addrErr  : registered, set with ready when the completed access was out of range
// Optional: define MEM_TRACE_EN to print one trace line per completed access (simulation).

`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned WORD_LEN    = `WORD_LEN,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = DefaultBaseAddr,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_R_EN,
  input  logic                MEM_W_EN,
  input  logic [WORD_LEN-1:0] address,
  input  logic [WORD_LEN-1:0] dataIn,
  output logic [WORD_LEN-1:0] dataOut,
  output logic                ready,
  output logic                stall,
  output logic                addrErr
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam logic [WORD_LEN-1:0] BaseAddr = WORD_LEN'(BASE_ADDR);
  // One bit wider so BASE_ADDR + 4*DEPTH cannot wrap.
  localparam logic [WORD_LEN:0] AddrLimit =
      (WORD_LEN+1)'(BASE_ADDR) + (WORD_LEN+1)'(4 * DEPTH);
  localparam logic [CntWidth-1:0] WaitInit = CntWidth'(WAIT_CYCLES);

  // Address translation and range check
  logic                req;
  logic [WORD_LEN-1:0] offset;
  logic                req_in_range;
  logic [IdxW-1:0]     req_idx;

  assign req          = MEM_R_EN | MEM_W_EN;
  assign offset       = address - BaseAddr;
  assign req_in_range = (address >= BaseAddr) && ({1'b0, address} < AddrLimit);
  assign req_idx      = offset[IdxW+1:2];

  logic unused_offset;
  assign unused_offset = ^{offset[1:0], offset[WORD_LEN-1:IdxW+2]};

  // State
  state_e               state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 op_write_q, op_write_d;
  logic                 in_range_q, in_range_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [WORD_LEN-1:0]  wdata_q, wdata_d;
  logic [WORD_LEN-1:0]  addr_q, addr_d;
  logic                 ready_q, ready_d;
  logic                 addr_err_q, addr_err_d;
  logic [WORD_LEN-1:0]  data_out_q, data_out_d;

  logic                 mem_we;
  logic [WORD_LEN-1:0]  mem_rdata;

  mem_word_array #(
    .WORD_LEN (WORD_LEN),
    .DEPTH    (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    in_range_d = in_range_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    ready_d    = 1'b0;
    addr_err_d = addr_err_q;
    data_out_d = data_out_q;
    mem_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          op_write_d = MEM_W_EN;  // both enables set -> write
          in_range_d = req_in_range;
          idx_d      = req_idx;
          wdata_d    = dataIn;
          addr_d     = address;
          cnt_d      = WaitInit;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntWidth'(1);
        end else begin
          // Access happens on this edge; out-of-range writes are dropped.
          mem_we = op_write_q & in_range_q;
          if (!op_write_q) begin
            data_out_d = in_range_q ? mem_rdata : '0;
          end
          addr_err_d = ~in_range_q;
          ready_d    = 1'b1;
          state_d    = StDone;
        end
      end
      StDone: begin
        addr_err_d = 1'b0;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      in_range_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      ready_q    <= 1'b0;
      addr_err_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      in_range_q <= in_range_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      ready_q    <= ready_d;
      addr_err_q <= addr_err_d;
      data_out_q <= data_out_d;
    end
  end

  assign dataOut = data_out_q;
  assign ready   = ready_q;
  assign addrErr = addr_err_q;
  assign stall   = req & ~ready_q;

`ifdef MEM_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && state_q == StDone) begin
      $display("MEM %s addr=0x%08h idx=%0d data=0x%08h addrErr=%0b",
               op_write_q ? "W" : "R", addr_q, idx_q,
               op_write_q ? wdata_q : data_out_q, addr_err_q);
    end
  end
`else
  logic unused_trace;
  assign unused_trace = ^addr_q;
`endif

endmodule
